// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
//
// Purpose
//   Turns 20 raw push-buttons into one 5-bit key code per press for the lock FSM.
//   Codes 0..15 are hex digits and 16 is W.
//   The buttons pass through a synchroniser and a priority encoder, so the
//   highest pressed index wins. The result is then debounced, and each accepted
//   press is presented exactly once.
//
//   keyout carries the code only in the single cycle where strobe is high. In
//   every other cycle it holds IDLE_CODE. IDLE_CODE never matches a key, so the
//   consumer may sample keyout every cycle without looking at strobe.
//
// Parameters
//   SYNC_STAGES      flops in the button synchroniser chain (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a press or a
//                    release (>= 1)
//   IDLE_CODE        keyout value when no key event is presented
//
// Ports
//   clk        in   1   system clock, all logic on posedge
//   rst_n      in   1   asynchronous, active-low reset
//   pb         in   20  raw asynchronous buttons, pb[i] high = button i pressed
//   keyout     out  5   key code (0..19) in the strobe cycle, IDLE_CODE otherwise
//   strobe     out  1   one-cycle pulse marking a newly accepted press
//   dbg_state  out  2   current debounce FSM state (debug observation only):
//                       0 IDLE, 1 DB_PRESS, 2 HOLD, 3 DB_REL
//
// Output handshake
//   strobe is a pure valid pulse with no ready/back-pressure. When strobe is
//   high, keyout is valid for that cycle only. When strobe is low, keyout is
//   IDLE_CODE. Presses are never queued. A press that the consumer misses is
//   lost.
// -----------------------------------------------------------------------------
module keypad_encoder #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter logic [4:0]  IDLE_CODE       = 5'h1F
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [19:0] pb,
   output logic [4:0]  keyout,
   output logic        strobe,
   output logic [1:0]  dbg_state
);

   // --------------------------------------------------------------------------
   // Local types and constants
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DB_PRESS = 2'd1,
      S_HOLD     = 2'd2,
      S_DB_REL   = 2'd3
   } state_e;

   // The counter only ever reaches DEBOUNCE_CYCLES-1.
   // It is kept at least 1 bit wide so that DEBOUNCE_CYCLES == 1 still elaborates.
   localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // --------------------------------------------------------------------------
   // Button synchroniser
   // Each bit gets its own SYNC_STAGES-deep chain. Bits are not skew-matched
   // against each other. Any resulting single-cycle code glitch is caught by
   // the code!=cand check during press debounce.
   // --------------------------------------------------------------------------
   logic [19:0] sync_q [SYNC_STAGES];
   logic [19:0] pb_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= pb;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign pb_s = sync_q[SYNC_STAGES-1];

   // --------------------------------------------------------------------------
   // Priority encoder: the loop runs low to high, so the last hit is the
   // highest set index and that index wins.
   // --------------------------------------------------------------------------
   logic       any;
   logic [4:0] code;

   assign any = |pb_s;

   always_comb begin
      code = 5'd0;
      for (int i = 0; i < 20; i++) begin
         if (pb_s[i]) begin
            code = 5'(i);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Debounce FSM: state register and registered outputs
   // --------------------------------------------------------------------------
   state_e           state_q,  state_d;
   logic [4:0]       cand_q,   cand_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [4:0]       keyout_q, keyout_d;
   logic             strobe_q, strobe_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cand_q   <= 5'd0;
         cnt_q    <= '0;
         keyout_q <= IDLE_CODE;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         keyout_q <= keyout_d;
         strobe_q <= strobe_d;
      end
   end

   // --------------------------------------------------------------------------
   // Debounce FSM: next-state and output logic
   // The outputs default to the idle pair. Only the DB_PRESS -> HOLD transition
   // presents a key, so the strobe pulse is exactly one cycle long by
   // construction.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      keyout_d = IDLE_CODE;
      strobe_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (any) begin
               state_d = S_DB_PRESS;
               cand_d  = code;
               cnt_d   = '0;
            end
         end

         S_DB_PRESS: begin
            // If the key is lost or the winning code changes, restart from
            // IDLE. IDLE then picks up the new code on the next cycle.
            if (!any || (code != cand_q)) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = S_HOLD;
               keyout_d = cand_q;
               strobe_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_HOLD: begin
            // While a key is held, extra or changed keys are deliberately
            // ignored. Only a full release re-arms the encoder.
            if (!any) begin
               state_d = S_DB_REL;
               cnt_d   = '0;
            end
         end

         S_DB_REL: begin
            if (any) begin
               state_d = S_HOLD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign keyout    = keyout_q;
   assign strobe    = strobe_q;
   assign dbg_state = state_q;

   // --------------------------------------------------------------------------
   // Embedded properties of the output contract
   // --------------------------------------------------------------------------
   strobe_single_cycle: assert property (
      @(posedge clk) disable iff (!rst_n) strobe_q |=> !strobe_q);

   strobe_code_in_range: assert property (
      @(posedge clk) disable iff (!rst_n) strobe_q |-> (keyout_q < 5'd20));

   keyout_idle_when_quiet: assert property (
      @(posedge clk) disable iff (!rst_n) !strobe_q |-> (keyout_q == IDLE_CODE));

endmodule

// File: tb/tb_keypad_encoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_encoder
//
// Self-checking bench for keypad_encoder with default parameters.
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge.
//
// A press driven at the falling edge after posedge D is first sampled at edge
// D+1 (edge 0). The strobe is then visible in the cycle after edge D+1+6, so
// the monitor sees it at the falling edge where cyc == D+7.
// -----------------------------------------------------------------------------
module tb_keypad_encoder;

   localparam logic [4:0] IDLE = 5'h1F;
   localparam int         LAT  = 2 + 4 + 1;

   // ---------------------------------------------------------------------------
   // Clock and reset
   // ---------------------------------------------------------------------------
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [19:0] pb    = '0;
   logic [4:0]  keyout;
   logic        strobe;
   logic [1:0]  dbg_state;
   int          cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   keypad_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pb        (pb),
      .keyout    (keyout),
      .strobe    (strobe),
      .dbg_state (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [4:0] exp_q[$];
   int         exp_cyc_q[$];
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_key(input logic [4:0] code, input int at_cyc);
      exp_q.push_back(code);
      exp_cyc_q.push_back(at_cyc);
   endtask

   // Every falling edge: a strobe must match the head of the queue, both in
   // code and in cycle. Without a strobe, keyout must be idle.
   always @(negedge clk) begin
      if (strobe) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 32'(strobe), 32'd0);
         end else begin
            logic [4:0] c;
            int         t;
            c = exp_q.pop_front();
            t = exp_cyc_q.pop_front();
            chk("strobe_code", 32'(keyout), 32'(c));
            chk("strobe_cycle", 32'(cyc), 32'(t));
         end
      end else begin
         chk("idle_keyout", 32'(keyout), 32'(IDLE));
      end
   end

   // ---------------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------------
   task automatic press(input logic [19:0] p, input int hold, input logic exp_s,
                        input logic [4:0] code);
      pb = p;
      if (exp_s) expect_key(code, cyc + LAT);
      repeat (hold) @(negedge clk);
      pb = '0;
      repeat (12) @(negedge clk);
   endtask

   typedef struct {
      logic [19:0] pb;
      int          hold;
      logic        exp_s;
      logic [4:0]  code;
   } vec_t;

   vec_t vecs[11];

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      vecs[0]  = '{20'h10000, 20, 1'b1, 5'd16};   // W, long hold
      vecs[1]  = '{20'h00008,  8, 1'b1, 5'd3};
      vecs[2]  = '{20'h00001,  8, 1'b1, 5'd0};
      vecs[3]  = '{20'h08000,  8, 1'b1, 5'd15};
      vecs[4]  = '{20'h80000,  8, 1'b1, 5'd19};
      vecs[5]  = '{20'h80001,  8, 1'b1, 5'd19};   // highest index wins
      vecs[6]  = '{20'h01810,  8, 1'b1, 5'd12};
      vecs[7]  = '{20'h00040,  4, 1'b0, 5'd0};    // one cycle too short
      vecs[8]  = '{20'h00040,  5, 1'b1, 5'd6};    // minimum accepted press
      vecs[9]  = '{20'hFFFFF,  8, 1'b1, 5'd19};
      vecs[10] = '{20'h00204, 10, 1'b1, 5'd9};    // pb[2] and pb[9] together

      // 1. Reset held while a key is pressed
      pb    = 20'h10000;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_keyout", 32'(keyout), 32'(IDLE));
      chk("reset_strobe", 32'(strobe), 32'd0);
      chk("reset_state", 32'(dbg_state), 32'd0);
      rst_n = 1'b1;
      expect_key(5'd16, cyc + LAT);
      repeat (15) @(negedge clk);
      pb = '0;
      repeat (12) @(negedge clk);

      // 2. Table-driven presses
      for (int i = 0; i < 11; i++) begin
         press(vecs[i].pb, vecs[i].hold, vecs[i].exp_s, vecs[i].code);
      end

      // 3. Press bounce on pb[5]: 2 high / 1 low, three times, then stable
      for (int k = 0; k < 3; k++) begin
         pb = 20'h00020;
         repeat (2) @(negedge clk);
         pb = '0;
         @(negedge clk);
      end
      pb = 20'h00020;
      expect_key(5'd5, cyc + LAT);
      repeat (15) @(negedge clk);
      pb = '0;
      repeat (12) @(negedge clk);

      // 4. Simultaneous pb[2] and pb[9], then pb[2] alone, then release:
      //    only the first strobe is produced
      pb = 20'h00204;
      expect_key(5'd9, cyc + LAT);
      repeat (10) @(negedge clk);
      pb = 20'h00004;
      repeat (10) @(negedge clk);
      pb = '0;
      repeat (12) @(negedge clk);

      // 5. Release bounce on pb[7]
      pb = 20'h00080;
      expect_key(5'd7, cyc + LAT);
      repeat (10) @(negedge clk);
      pb = '0;
      repeat (2) @(negedge clk);
      pb = 20'h00080;
      repeat (2) @(negedge clk);
      pb = '0;
      repeat (12) @(negedge clk);

      // 6. One-cycle reset pulse after edge 4 of a pb[1] press
      pb = 20'h00002;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_keyout", 32'(keyout), 32'(IDLE));
      chk("midreset_strobe", 32'(strobe), 32'd0);
      chk("midreset_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_key(5'd1, cyc + LAT);
      repeat (20) @(negedge clk);
      pb = '0;
      repeat (12) @(negedge clk);

      // Every expected strobe must have been consumed
      chk("missing_strobes", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
